// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multi-cycle RV32I core: sequences fetch/decode/execute/memory/writeback,
// drives every datapath select, handshakes with the shared memory port and counts retirements.
module multicycle_control_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        branch_cond,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_write,
  output logic        adr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        reg_write,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  result_src,
  output logic        illegal,
  output logic [31:0] instret
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite, StExecR, StExecI,
    StLui, StAuipc, StAluWb, StJal, StJalr, StBranch, StTrap
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] instret_q;
  logic        retire;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:    if (mem_ready) state_d = StDecode;
      StDecode: begin
        unique case (opcode)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecR;
          OpIType:         state_d = StExecI;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = StJal;
          OpJalr:          state_d = StJalr;
          OpLui:           state_d = StLui;
          OpAuipc:         state_d = StAuipc;
          default:         state_d = StTrap;
        endcase
      end
      // opcode bit 5 separates stores from loads
      StMemAdr:   state_d = opcode[5] ? StMemWrite : StMemRead;
      StMemRead:  if (mem_ready) state_d = StMemWb;
      StMemWrite: if (mem_ready) state_d = StFetch;
      StExecR, StExecI, StLui, StAuipc: state_d = StAluWb;
      StMemWb, StAluWb, StJal, StJalr, StBranch: state_d = StFetch;
      StTrap:     state_d = StTrap;
      default:    state_d = StFetch;
    endcase
  end

  assign retire = (state_d == StFetch) && (state_q != StFetch) && (state_q != StTrap);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instret_q <= instret_q + 32'd1;
    end
  end

  // Outputs decode from the current state; reset masks everything to zero in the same cycle.
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    illegal    = 1'b0;
    if (!reset) begin
      unique case (state_q)
        StFetch: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            alu_src_b = 2'b10;
          end
        end
        StDecode: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
        end
        StMemAdr: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
        end
        StMemRead: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        StMemWb: begin
          result_src = 2'b01;
          reg_write  = 1'b1;
        end
        StMemWrite: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          adr_src   = 1'b1;
        end
        StExecR: begin
          alu_src_a = 2'b10;
          alu_op    = 2'b10;
        end
        StExecI: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          alu_op    = 2'b10;
        end
        StLui: begin
          alu_src_a = 2'b11;
          alu_src_b = 2'b01;
        end
        StAuipc: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
        end
        StAluWb:  reg_write = 1'b1;
        StJal: begin
          pc_write   = 1'b1;
          pc_src     = 1'b1;
          result_src = 2'b10;
          reg_write  = 1'b1;
        end
        StJalr: begin
          alu_src_a  = 2'b10;
          alu_src_b  = 2'b01;
          pc_write   = 1'b1;
          result_src = 2'b10;
          reg_write  = 1'b1;
        end
        StBranch: begin
          alu_src_a = 2'b10;
          alu_op    = 2'b01;
          pc_src    = 1'b1;
          pc_write  = branch_cond;
        end
        StTrap:  illegal = 1'b1;
        default: ;
      endcase
    end
  end

  assign instret = reset ? 32'd0 : instret_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench: an instruction-level model expands each instruction into its expected
// per-cycle control outputs; a compare process checks every cycle against that expectation.
module tb_multicycle_control_fsm;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpBad    = 7'b1111111;

  logic        clk = 1'b0;
  logic        reset, branch_cond, mem_ready;
  logic [6:0]  opcode;
  logic        mem_req, mem_write, adr_src, ir_write, pc_write, pc_src, reg_write, illegal;
  logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
  logic [31:0] instret;

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .branch_cond(branch_cond), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src), .illegal(illegal),
    .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, pc_src, reg_write;
    logic [1:0] a, b, op, rs;
    logic       illegal;
  } outs_t;

  outs_t       act, exp_o;
  logic [31:0] exp_cnt, model_cnt;
  string       exp_tag;
  bit          exp_valid = 1'b0;
  int          n_tests = 0, n_fail = 0, ncyc = 0, c;

  assign act = {mem_req, mem_write, adr_src, ir_write, pc_write, pc_src, reg_write,
                alu_src_a, alu_src_b, alu_op, result_src, illegal};

  always @(negedge clk) begin
    #2;
    if (exp_valid) begin
      n_tests++;
      if (act !== exp_o) begin
        n_fail++;
        $display("FAIL outs[%s] t=%0t got %h want %h", exp_tag, $time, act, exp_o);
      end
      n_tests++;
      if (instret !== exp_cnt) begin
        n_fail++;
        $display("FAIL instret[%s] t=%0t got %h want %h", exp_tag, $time, instret, exp_cnt);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  // One clock: drive inputs at the falling edge, publish the expectation, advance the model.
  task automatic step(input string tag, input outs_t e, input logic rdy, input logic rst,
                      input bit ret);
    @(negedge clk);
    reset     = rst;
    mem_ready = rdy;
    exp_o     = e;
    exp_cnt   = rst ? 32'd0 : model_cnt;
    exp_tag   = tag;
    exp_valid = 1'b1;
    ncyc++;
    @(posedge clk);
    if (rst) model_cnt = 32'd0;
    else if (ret) model_cnt = model_cnt + 32'd1;
  endtask

  // Expands one instruction into its cycle-by-cycle control pattern. For loads/stores 'stall'
  // counts mem_ready=0 cycles in the data phase; for an illegal opcode it is the TRAP hold time.
  task automatic run(input string tag, input logic [6:0] op, input int fstall, input int stall,
                     input logic bc, output int cycles);
    outs_t e;
    int    c0 = ncyc;
    opcode = op;
    branch_cond = bc;
    repeat (fstall) begin
      e = '0; e.mem_req = 1'b1;
      step(tag, e, 1'b0, 1'b0, 1'b0);
    end
    e = '0; e.mem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1; e.b = 2'b10;
    step(tag, e, 1'b1, 1'b0, 1'b0);
    e = '0; e.a = 2'b01; e.b = 2'b01;
    step(tag, e, 1'b0, 1'b0, 1'b0);
    case (op)
      OpLoad, OpStore: begin
        e = '0; e.a = 2'b10; e.b = 2'b01;
        step(tag, e, 1'b1, 1'b0, 1'b0);
        e = '0; e.mem_req = 1'b1; e.adr_src = 1'b1; e.mem_write = (op == OpStore);
        repeat (stall) step(tag, e, 1'b0, 1'b0, 1'b0);
        step(tag, e, 1'b1, 1'b0, op == OpStore);
        if (op == OpLoad) begin
          e = '0; e.rs = 2'b01; e.reg_write = 1'b1;
          step(tag, e, 1'b1, 1'b0, 1'b1);
        end
      end
      OpRType, OpIType, OpLui, OpAuipc: begin
        e = '0;
        e.a  = (op == OpLui) ? 2'b11 : (op == OpAuipc) ? 2'b01 : 2'b10;
        e.b  = (op == OpRType) ? 2'b00 : 2'b01;
        e.op = (op == OpRType || op == OpIType) ? 2'b10 : 2'b00;
        step(tag, e, 1'b0, 1'b0, 1'b0);
        e = '0; e.reg_write = 1'b1;
        step(tag, e, 1'b1, 1'b0, 1'b1);
      end
      OpJal: begin
        e = '0; e.pc_write = 1'b1; e.pc_src = 1'b1; e.rs = 2'b10; e.reg_write = 1'b1;
        step(tag, e, 1'b0, 1'b0, 1'b1);
      end
      OpJalr: begin
        e = '0; e.a = 2'b10; e.b = 2'b01; e.pc_write = 1'b1; e.rs = 2'b10; e.reg_write = 1'b1;
        step(tag, e, 1'b1, 1'b0, 1'b1);
      end
      OpBranch: begin
        e = '0; e.a = 2'b10; e.op = 2'b01; e.pc_src = 1'b1; e.pc_write = bc;
        step(tag, e, 1'b0, 1'b0, 1'b1);
      end
      default: begin
        e = '0; e.illegal = 1'b1;
        repeat (stall) step(tag, e, 1'b1, 1'b0, 1'b0);
      end
    endcase
    cycles = ncyc - c0;
  endtask

  initial begin
    outs_t e;
    reset = 1'b1; opcode = '0; branch_cond = 1'b0; mem_ready = 1'b0; model_cnt = '0;
    step("reset", '0, 1'b1, 1'b1, 1'b0);

    run("rtype", OpRType, 0, 0, 1'b0, c);   chk("lat_rtype", c, 4);
    #1 chk("instret_rtype", instret, 32'd1);
    run("load", OpLoad, 0, 3, 1'b0, c);     chk("lat_load_stall3", c, 8);
    #1 chk("instret_load", instret, 32'd2);
    run("store", OpStore, 1, 0, 1'b0, c);   chk("lat_store_fstall1", c, 5);
    run("itype", OpIType, 0, 0, 1'b0, c);   chk("lat_itype", c, 4);
    run("lui", OpLui, 0, 0, 1'b0, c);       chk("lat_lui", c, 4);
    run("auipc", OpAuipc, 0, 0, 1'b0, c);   chk("lat_auipc", c, 4);
    run("jal", OpJal, 0, 0, 1'b0, c);       chk("lat_jal", c, 3);
    run("jalr", OpJalr, 0, 0, 1'b0, c);     chk("lat_jalr", c, 3);
    run("beq_nt", OpBranch, 0, 0, 1'b0, c); chk("lat_branch", c, 3);
    run("beq_t", OpBranch, 0, 0, 1'b1, c);
    #1 chk("instret_after_branches", instret, 32'd10);
    run("trap", OpBad, 0, 10, 1'b0, c);     chk("lat_trap_hold", c, 12);
    #1 chk("instret_trap", instret, 32'd10);
    chk("illegal_sticky", {31'd0, illegal}, 32'd1);

    step("reset_trap", '0, 1'b1, 1'b1, 1'b0);
    run("rtype_after_trap", OpRType, 0, 0, 1'b0, c);
    #1 chk("instret_restart", instret, 32'd1);

    // Preload the counter just below wrap; the next retirement must roll it to zero.
    force dut.instret_q = 32'hFFFF_FFFF;
    #1 release dut.instret_q;
    model_cnt = 32'hFFFF_FFFF;
    run("wrap", OpRType, 0, 0, 1'b0, c);
    #1 chk("instret_wrap", instret, 32'd0);

    // Reset lands while a store is stalled: the request must drop that same cycle.
    opcode = OpStore;
    e = '0; e.mem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1; e.b = 2'b10;
    step("st_rst", e, 1'b1, 1'b0, 1'b0);
    e = '0; e.a = 2'b01; e.b = 2'b01;
    step("st_rst", e, 1'b0, 1'b0, 1'b0);
    e = '0; e.a = 2'b10; e.b = 2'b01;
    step("st_rst", e, 1'b0, 1'b0, 1'b0);
    e = '0; e.mem_req = 1'b1; e.mem_write = 1'b1; e.adr_src = 1'b1;
    step("st_rst", e, 1'b0, 1'b0, 1'b0);
    step("st_rst", e, 1'b0, 1'b0, 1'b0);
    step("st_rst_reset", '0, 1'b0, 1'b1, 1'b0);
    run("rtype_after_rst", OpRType, 0, 0, 1'b0, c);
    #1 chk("instret_after_rst", instret, 32'd1);

    @(negedge clk);
    exp_valid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
